// File: rtl/pipelined_adder.sv
// Add/subtract unit with the carry chain cut into STAGES chunks, one register per chunk.
// Result appears STAGES enabled edges after sampling; en=0 freezes everything (no internal backpressure).
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] Y,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO
);

    // STAGES must lie in 1..8 and divide WIDTH evenly.
    localparam int CHUNK = WIDTH / STAGES;

    logic [WIDTH-1:0] w_fin_y;
    logic             w_fin_c;
    logic             w_fin_ovf;
    logic             w_fin_vld;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stg
            localparam int LO = k * CHUNK;
            localparam int UW = WIDTH - LO;

            // Operand bits not yet consumed; this stage's chunk sits at the bottom.
            logic [UW-1:0]         w_a;
            logic [UW-1:0]         w_b;
            logic [LO+CHUNK-1:0]   w_y;
            logic                  w_ci;
            logic                  w_sub;
            logic                  w_vld;
            logic [CHUNK-1:0]      w_bx;
            logic [CHUNK:0]        w_sum;

            assign w_bx  = w_b[CHUNK-1:0] ^ {CHUNK{w_sub}};
            assign w_sum = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_bx} + {{CHUNK{1'b0}}, w_ci};

            if (k == 0) begin : g_in
                assign w_a   = A;
                assign w_b   = B;
                assign w_ci  = SUB;
                assign w_sub = SUB;
                assign w_vld = in_valid;
                assign w_y   = w_sum[CHUNK-1:0];
            end else begin : g_in
                assign w_a   = g_stg[k-1].g_reg.r_a;
                assign w_b   = g_stg[k-1].g_reg.r_b;
                assign w_ci  = g_stg[k-1].g_reg.r_c;
                assign w_sub = g_stg[k-1].g_reg.r_sub;
                assign w_vld = g_stg[k-1].g_reg.r_vld;
                assign w_y   = {w_sum[CHUNK-1:0], g_stg[k-1].g_reg.r_y};
            end

            if (k < STAGES - 1) begin : g_reg
                logic [UW-CHUNK-1:0] r_a;
                logic [UW-CHUNK-1:0] r_b;
                logic [LO+CHUNK-1:0] r_y;
                logic                r_c;
                logic                r_sub;
                logic                r_vld;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_a   <= '0;
                        r_b   <= '0;
                        r_y   <= '0;
                        r_c   <= 1'b0;
                        r_sub <= 1'b0;
                        r_vld <= 1'b0;
                    end else if (en) begin
                        r_a   <= w_a[UW-1:CHUNK];
                        r_b   <= w_b[UW-1:CHUNK];
                        r_y   <= w_y;
                        r_c   <= w_sum[CHUNK];
                        r_sub <= w_sub;
                        r_vld <= w_vld;
                    end
                end
            end else begin : g_out
                assign w_fin_y   = w_y;
                assign w_fin_c   = w_sum[CHUNK];
                assign w_fin_vld = w_vld;
                // Top chunk holds the MSBs of A, B' and Y.
                assign w_fin_ovf = (w_a[CHUNK-1] == w_bx[CHUNK-1]) &&
                                   (w_sum[CHUNK-1] != w_a[CHUNK-1]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Y         <= '0;
            COUT      <= 1'b0;
            OVF       <= 1'b0;
            ZERO      <= 1'b0;
        end else if (en) begin
            out_valid <= w_fin_vld;
            if (w_fin_vld) begin
                Y    <= w_fin_y;
                COUT <= w_fin_c;
                OVF  <= w_fin_ovf;
                ZERO <= ~|w_fin_y;
            end
        end
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; successor to the single-cycle 32-bit combinational adder.
- Splits the WIDTH-bit carry chain into STAGES equal chunks, with one register boundary per chunk.
- Accepts one operation per cycle and flags results with a valid strobe.
- Serves the ALU/branch-target datapath where the combinational carry chain limits clock frequency.

Parameters:
WIDTH, 32, operand/result width in bits
STAGES, 4, pipeline depth = number of carry chunks; legal 1..8, must divide WIDTH (CHUNK = WIDTH/STAGES)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  pipeline advance; 0 = all pipeline and output registers hold
in_valid  input  1  A/B/SUB carry a new operation this cycle
SUB  input  1  0 = A+B, 1 = A-B
A  input  WIDTH  operand A (two's complement or unsigned)
B  input  WIDTH  operand B
out_valid  output  1  one-cycle strobe: Y/COUT/OVF/ZERO hold a new result
Y  output  WIDTH  sum/difference modulo 2^WIDTH
COUT  output  1  carry out of MSB; for SUB, 1 = no borrow (A >= B unsigned)
OVF  output  1  signed two's-complement overflow
ZERO  output  1  Y == 0

Behaviour:
- Reset, asynchronous on rst_n low:
  - all stage registers, valid bits and carries clear;
  - out_valid=0, Y=0, COUT=0, OVF=0, ZERO=0.
  - In-flight operations are discarded, not completed.
  - Reset release is synchronised by the system; the block needs no extra logic for it.
- Arithmetic:
  - B' = B XOR {WIDTH{SUB}}, carry-in = SUB.
  - Y = A + B' + SUB, truncated to WIDTH.
  - OVF = (A[MSB] == B'[MSB]) AND (Y[MSB] != A[MSB]).
  - ZERO = ~|Y.
- Stage k (0..STAGES-1):
  - adds chunk k of A and B' plus the carry registered by stage k-1 (stage 0 uses SUB);
  - registers the chunk sum and chunk carry-out.
  - Upper operand chunks and the SUB bit are skewed through delay registers.
  - Lower result chunks are delayed so all chunks of one operation align at the last stage.
- Latency:
  - Operation sampled at edge n (en=1) appears on the outputs after edge n+STAGES-1, counting only edges with en=1.
  - STAGES=1 gives a single registered adder.
  - Throughput is one operation per enabled cycle.
- Valid tracking:
  - in_valid travels with its data through a STAGES-deep valid shift register.
  - Bubbles (in_valid=0) propagate as bubbles.
- Output update:
  - Y/COUT/OVF/ZERO load only when the last stage holds a valid operation.
  - Otherwise they keep their previous value.
  - out_valid is high for exactly the enabled cycle after the result loads.
  - out_valid drops to 0 on the next enabled edge unless another valid result arrives.
- Stall (en=0):
  - every register, including out_valid and the outputs, holds;
  - in_valid/A/B/SUB are ignored.
  - A stall never drops, duplicates or reorders operations.
- Back-to-back operations with mixed SUB values must each use their own SUB, which is carried per stage.
- Overflow and carry wrap modulo 2^WIDTH; there is no saturation.

Test Plan:
- WIDTH=32, STAGES=4: A=0x0000000A, B=0x00000014, SUB=0, one valid cycle -> after 4 edges out_valid=1 for 1 cycle, Y=0x0000001E, COUT=0, OVF=0, ZERO=0.
- A=-10, B=-20, SUB=0 -> Y=0xFFFFFFE2, COUT=1, OVF=0. Then A=15, B=5, SUB=1 on the next cycle -> next cycle Y=0x0000000A, COUT=1. Proves per-operation SUB and one result per cycle.
- Boundaries:
  - A=0x7FFFFFFF, B=1, SUB=0 -> Y=0x80000000, OVF=1, COUT=0.
  - A=0, B=1, SUB=1 -> Y=0xFFFFFFFF, COUT=0, OVF=0.
  - A=5, B=5, SUB=1 -> Y=0, ZERO=1, COUT=1.
  - A=0xFFFFFFFF, B=1, SUB=0 -> Y=0, COUT=1, ZERO=1 (carry ripples across all 4 chunks).
- Stream of 6 operations with a bubble after #2 and en=0 for 3 cycles mid-stream -> exactly 6 out_valid strobes, in order, with correct values. Outputs and out_valid frozen during the stall; latency extended by exactly 3 cycles.
- rst_n asserted asynchronously (between edges) with 3 operations in flight -> outputs and out_valid go to 0 immediately. No out_valid after release until a new operation is sent; that operation completes with full latency.
- Repeat the first three scenarios with STAGES=1 (result 1 edge after sampling) and WIDTH=16, STAGES=8 (0x7FFF+1 -> 0x8000, OVF=1).
